// File: rtl/regfile_wb_sequencer_if.sv
// rtl/regfile_wb_sequencer_if.sv - writeback request and regfile write-port bundle
//
// Purpose: groups the writeback request handshake (from execute/ALU) and the
// regfile write strobes/status driven by regfile_wb_sequencer.
// Ports (signals):
//   req_valid/req_ready          request handshake
//   req_kind/req_dst/req_data/req_flags   request payload
//   reg8_we/reg8_dst/reg8_data   8-bit regfile write port
//   reg16_we/reg16_dst/reg16_data  16-bit regfile write port
//   flags_we/flags               flags write port
//   busy/err                     status
// Modports: master = request producer / regfile side, slave = sequencer.

interface regfile_wb_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [15:0] req_dst;
  logic [15:0] req_data;
  logic [7:0]  req_flags;

  logic        reg8_we;
  logic [7:0]  reg8_dst;
  logic [7:0]  reg8_data;
  logic        reg16_we;
  logic [15:0] reg16_dst;
  logic [15:0] reg16_data;
  logic        flags_we;
  logic [7:0]  flags;
  logic        busy;
  logic        err;

  modport master (
    output req_valid, req_kind, req_dst, req_data, req_flags,
    input  req_ready,
    input  reg8_we, reg8_dst, reg8_data,
    input  reg16_we, reg16_dst, reg16_data,
    input  flags_we, flags, busy, err
  );

  modport slave (
    input  req_valid, req_kind, req_dst, req_data, req_flags,
    output req_ready,
    output reg8_we, reg8_dst, reg8_data,
    output reg16_we, reg16_dst, reg16_data,
    output flags_we, flags, busy, err
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// rtl/regfile_wb_sequencer.sv - writeback FIFO draining onto regfile write ports
//
// Purpose: buffers writeback requests in a DEPTH-entry FIFO and issues one
// regfile write strobe per cycle; reg8+flags requests take two cycles.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   wb     slave modport of regfile_wb_sequencer_if (request in, writes out)

module regfile_wb_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_sequencer_if.slave  wb
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] K_REG8  = 2'd0;
  localparam logic [1:0] K_REG16 = 2'd1;
  localparam logic [1:0] K_FLAGS = 2'd2;
  localparam logic [1:0] K_BOTH  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_FLAGS
  } state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] dst;
    logic [15:0] data;
    logic [7:0]  flags;
  } entry_t;

  // FIFO storage and pointers
  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  // sequencer state
  state_t          state_q, state_d;
  logic [7:0]      stash_q, stash_d;

  // registered outputs
  logic            reg8_we_q, reg8_we_d;
  logic [7:0]      reg8_dst_q, reg8_dst_d;
  logic [7:0]      reg8_data_q, reg8_data_d;
  logic            reg16_we_q, reg16_we_d;
  logic [15:0]     reg16_dst_q, reg16_dst_d;
  logic [15:0]     reg16_data_q, reg16_data_d;
  logic            flags_we_q, flags_we_d;
  logic [7:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            full;
  logic            push;
  logic            pop;
  entry_t          head;
  logic            dst8_ok;
  logic            dst16_ok;
  logic            head_legal;

  assign full = (count_q == FULL_CNT);
  assign head = fifo_q[rd_ptr_q];

  assign dst8_ok  = (head.dst <= 16'h0006);
  assign dst16_ok = (head.dst == 16'h0007) || (head.dst == 16'h0008) ||
                    (head.dst == 16'h0009) || (head.dst == 16'h0010);

  always_comb begin
    head_legal = 1'b0;
    case (head.kind)
      K_REG8,
      K_BOTH:  head_legal = dst8_ok;
      K_REG16: head_legal = dst16_ok;
      default: head_legal = 1'b1;   // flags-only ignores dst
    endcase
  end

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    stash_d      = stash_q;
    reg8_we_d    = 1'b0;
    reg8_dst_d   = reg8_dst_q;
    reg8_data_d  = reg8_data_q;
    reg16_we_d   = 1'b0;
    reg16_dst_d  = reg16_dst_q;
    reg16_data_d = reg16_data_q;
    flags_we_d   = 1'b0;
    flags_d      = flags_q;
    err_d        = 1'b0;
    pop          = 1'b0;

    // Full blocks the push even if a pop frees a slot this cycle.
    push = wb.req_valid && !full;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (!head_legal) begin
            err_d = 1'b1;
          end else begin
            case (head.kind)
              K_REG8: begin
                reg8_we_d   = 1'b1;
                reg8_dst_d  = head.dst[7:0];
                reg8_data_d = head.data[7:0];
              end
              K_REG16: begin
                reg16_we_d   = 1'b1;
                reg16_dst_d  = head.dst;
                reg16_data_d = head.data;
              end
              K_FLAGS: begin
                flags_we_d = 1'b1;
                flags_d    = head.flags;
              end
              default: begin
                reg8_we_d   = 1'b1;
                reg8_dst_d  = head.dst[7:0];
                reg8_data_d = head.data[7:0];
                stash_d     = head.flags;
                state_d     = ST_FLAGS;
              end
            endcase
          end
        end
      end
      ST_FLAGS: begin
        // second half of a reg8+flags request; FIFO is not popped
        flags_we_d = 1'b1;
        flags_d    = stash_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = '{kind:  wb.req_kind,  dst:   wb.req_dst,
                           data:  wb.req_data,  flags: wb.req_flags};
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    busy_d = (count_d != '0) || (state_d != ST_IDLE);
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      stash_q      <= '0;
      reg8_we_q    <= 1'b0;
      reg8_dst_q   <= '0;
      reg8_data_q  <= '0;
      reg16_we_q   <= 1'b0;
      reg16_dst_q  <= '0;
      reg16_data_q <= '0;
      flags_we_q   <= 1'b0;
      flags_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      stash_q      <= stash_d;
      reg8_we_q    <= reg8_we_d;
      reg8_dst_q   <= reg8_dst_d;
      reg8_data_q  <= reg8_data_d;
      reg16_we_q   <= reg16_we_d;
      reg16_dst_q  <= reg16_dst_d;
      reg16_data_q <= reg16_data_d;
      flags_we_q   <= flags_we_d;
      flags_q      <= flags_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign wb.req_ready  = !full;
  assign wb.reg8_we    = reg8_we_q;
  assign wb.reg8_dst   = reg8_dst_q;
  assign wb.reg8_data  = reg8_data_q;
  assign wb.reg16_we   = reg16_we_q;
  assign wb.reg16_dst  = reg16_dst_q;
  assign wb.reg16_data = reg16_data_q;
  assign wb.flags_we   = flags_we_q;
  assign wb.flags      = flags_q;
  assign wb.busy       = busy_q;
  assign wb.err        = err_q;

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb/tb_regfile_wb_sequencer.sv - self-checking bench for regfile_wb_sequencer

module tb_regfile_wb_sequencer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] dst;
    logic [15:0] data;
    logic [7:0]  flags;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  regfile_wb_sequencer_if wb ();

  regfile_wb_sequencer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: queue of accepted requests plus one pending flags write
  ent_t       q[$];
  bit         pend;
  logic [7:0] stash;
  logic       e_r8we, e_r16we, e_fwe, e_err, e_busy, e_ready;
  logic [7:0] e_r8dst, e_r8data, e_flags;
  logic [15:0] e_r16dst, e_r16data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input ent_t e);
    case (e.kind)
      2'd0, 2'd3: return e.dst <= 16'd6;
      2'd1:       return (e.dst == 16'h7) || (e.dst == 16'h8) ||
                         (e.dst == 16'h9) || (e.dst == 16'h10);
      default:    return 1'b1;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [1:0] k, input logic [15:0] d,
                       input logic [15:0] dat, input logic [7:0] f);
    wb.req_valid = v;
    wb.req_kind  = k;
    wb.req_dst   = d;
    wb.req_data  = dat;
    wb.req_flags = f;
  endtask

  // advance one clock, updating the model from the inputs present at the edge
  task automatic tick();
    ent_t e;
    bit   push;
    e_r8we = 0; e_r16we = 0; e_fwe = 0; e_err = 0;
    if (reset) begin
      q.delete();
      pend = 0; stash = 0;
      e_r8dst = 0; e_r8data = 0; e_r16dst = 0; e_r16data = 0; e_flags = 0;
    end else begin
      push = wb.req_valid && (q.size() < DEPTH);
      if (pend) begin
        e_fwe = 1; e_flags = stash; pend = 0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (!legal(e)) e_err = 1;
        else begin
          case (e.kind)
            2'd0: begin e_r8we = 1; e_r8dst = e.dst[7:0]; e_r8data = e.data[7:0]; end
            2'd1: begin e_r16we = 1; e_r16dst = e.dst; e_r16data = e.data; end
            2'd2: begin e_fwe = 1; e_flags = e.flags; end
            default: begin
              e_r8we = 1; e_r8dst = e.dst[7:0]; e_r8data = e.data[7:0];
              pend = 1; stash = e.flags;
            end
          endcase
        end
      end
      if (push) q.push_back('{kind: wb.req_kind, dst: wb.req_dst,
                              data: wb.req_data, flags: wb.req_flags});
    end
    e_busy  = (q.size() != 0) || pend;
    e_ready = q.size() < DEPTH;
    @(posedge clk);
    #1;
    check("strobes", 32'({wb.reg8_we, wb.reg16_we, wb.flags_we, wb.err}),
                     32'({e_r8we, e_r16we, e_fwe, e_err}));
    check("reg8_port", 32'({wb.reg8_dst, wb.reg8_data}), 32'({e_r8dst, e_r8data}));
    check("reg16_port", {wb.reg16_dst, wb.reg16_data}, {e_r16dst, e_r16data});
    check("flags_port", 32'(wb.flags), 32'(e_flags));
    check("status", 32'({wb.req_ready, wb.busy}), 32'({e_ready, e_busy}));
  endtask

  function automatic logic [15:0] rand_dst();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 6));
      1:       return 16'($urandom_range(7, 10)) + ((($urandom_range(7, 10)) == 10) ? 16'd6 : 16'd0);
      2:       return 16'($urandom);
      default: return 16'($urandom_range(0, 18));
    endcase
  endfunction

  bit saw_full;

  initial begin
    pend = 0; stash = 0;
    e_r8dst = 0; e_r8data = 0; e_r16dst = 0; e_r16data = 0; e_flags = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_strobes", 32'({wb.reg8_we, wb.reg16_we, wb.flags_we, wb.err, wb.busy}), 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(wb.req_ready), 32'd1);

    // latency: pushed at edge N, strobe visible only after edge N+1
    drive(1, 2'd0, 16'h0000, 16'h0012, 8'h00);
    tick();
    check("lat_edge_n", 32'(wb.reg8_we), 32'd0);
    drive(0, 0, 0, 0, 0);
    tick();
    check("lat_edge_n1", 32'({wb.reg8_we, wb.reg8_dst, wb.reg8_data}), 32'({1'b1, 8'h00, 8'h12}));
    tick();
    check("lat_one_cycle", 32'(wb.reg8_we), 32'd0);

    // back-to-back 16-bit writes
    drive(1, 2'd1, 16'h0007, 16'hABCD, 8'h00);
    tick();
    drive(1, 2'd1, 16'h0010, 16'h8000, 8'h00);
    tick();
    drive(0, 0, 0, 0, 0);
    check("r16_first", 32'(wb.reg16_we), 32'd1);
    check("r16_first_val", {wb.reg16_dst, wb.reg16_data}, 32'h0007ABCD);
    tick();
    check("r16_second", 32'(wb.reg16_we), 32'd1);
    check("r16_second_val", {wb.reg16_dst, wb.reg16_data}, 32'h00108000);
    tick();

    // reg8+flags, then a queued 16-bit write on the third cycle
    drive(1, 2'd3, 16'h0000, 16'h0034, 8'hF0);
    tick();
    drive(1, 2'd1, 16'h0008, 16'h1234, 8'h00);
    tick();
    drive(0, 0, 0, 0, 0);
    check("k3_reg8", 32'({wb.reg8_we, wb.reg8_dst, wb.reg8_data}), 32'({1'b1, 8'h00, 8'h34}));
    tick();
    check("k3_flags", 32'({wb.flags_we, wb.flags, wb.reg16_we}), 32'({1'b1, 8'hF0, 1'b0}));
    tick();
    check("k3_next", {wb.reg16_dst, wb.reg16_data}, 32'h00081234);
    check("k3_next_we", 32'(wb.reg16_we), 32'd1);
    tick();

    // illegal destinations followed by a legal entry
    drive(1, 2'd0, 16'h0007, 16'h0011, 8'h00);
    tick();
    drive(1, 2'd1, 16'h0005, 16'h2222, 8'h00);
    tick();
    drive(1, 2'd0, 16'h0003, 16'h0055, 8'h00);
    check("illegal8_err", 32'({wb.err, wb.reg8_we, wb.reg16_we}), 32'b100);
    tick();
    drive(0, 0, 0, 0, 0);
    check("illegal16_err", 32'({wb.err, wb.reg8_we, wb.reg16_we}), 32'b100);
    tick();
    check("legal_after_err", 32'({wb.err, wb.reg8_we, wb.reg8_dst, wb.reg8_data}),
          32'({1'b0, 1'b1, 8'h03, 8'h55}));
    tick();

    // hold req_valid with two-cycle requests until the FIFO fills
    saw_full = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 2'd3, 16'(i % 7), 16'(8'h40 + i), 8'(8'hA0 + i));
      tick();
      if (!wb.req_ready) saw_full = 1;
    end
    drive(0, 0, 0, 0, 0);
    check("fifo_filled", 32'(saw_full), 32'd1);
    for (int i = 0; i < 24; i++) tick();
    check("drained_idle", 32'({wb.busy, wb.req_ready}), 32'b01);

    // reset during a pending flags write
    drive(1, 2'd0, 16'h0001, 16'h0066, 8'h00);
    tick();
    drive(1, 2'd3, 16'h0002, 16'h0077, 8'hAA);
    tick();
    drive(1, 2'd0, 16'h0004, 16'h0088, 8'h00);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (pend) break;
      tick();
    end
    check("flags_cycle_found", 32'(pend), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_flags", 32'({wb.flags_we, wb.busy, wb.req_ready}), 32'b001);
    for (int i = 0; i < 4; i++) tick();
    check("rst_no_strobes", 32'({wb.reg8_we, wb.reg16_we, wb.flags_we, wb.err}), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rand_dst(),
            16'($urandom), 8'($urandom));
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
